decode_stage: RTL and testbench

- ID pipeline stage between instruction fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and drives the register file read addresses.
- Bypasses same-cycle register file writes, forces x0 operands to zero, and generates the immediate.
- Inserts a one-cycle load-use bubble and registers everything into a ID/EX output register with its own valid/ready handshake.

---
 rtl/decode_stage.sv | 139 +++++++++++++
 tb/tb_decode_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, writeback bypass, x0 forcing,
// immediate generation, load-use bubble and the ID/EX output register.
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic            flush,
  output logic [4:0]      rf_read_adr1,
  output logic [4:0]      rf_read_adr2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic            wb_wend,
  input  logic [4:0]      wb_write_adr,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7_5
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            rs1_used;
  logic            rs2_used;
  logic            hazard;
  logic            adv;
  logic            xfer;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  assign rf_read_adr1 = rs1;
  assign rf_read_adr2 = rs2;

  // The register file does not hardwire x0, so zero is forced here first.
  assign rs1_data = (rs1 == 5'd0) ? '0 :
                    (wb_wend && wb_write_adr == rs1) ? wb_write_data : rf_read_data1;
  assign rs2_data = (rs2 == 5'd0) ? '0 :
                    (wb_wend && wb_write_adr == rs2) ? wb_write_data : rf_read_data2;

  always_comb begin
    imm = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{in_instr[31]}}, in_instr[31:20]};
      OP_STORE:
        imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_BRANCH:
        imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
               in_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {in_instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
               in_instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);

  assign hazard = in_valid && out_valid && (out_opcode == OP_LOAD) && (out_rd != 5'd0) &&
                  ((rs1_used && out_rd == rs1) || (rs2_used && out_rd == rs2));

  assign adv      = !out_valid || out_ready;
  assign in_ready = flush || (adv && !hazard);
  assign xfer     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7_5 <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= xfer;
      if (xfer) begin
        out_pc       <= in_pc;
        out_rs1_data <= rs1_data;
        out_rs2_data <= rs2_data;
        out_imm      <= imm;
        out_rs1      <= rs1;
        out_rs2      <= rs2;
        out_rd       <= rd;
        out_opcode   <= opcode;
        out_funct3   <= in_instr[14:12];
        out_funct7_5 <= in_instr[30];
      end
    end else begin
      // Stalled by execute: keep operands fresh against writebacks landing meanwhile.
      if (wb_wend && out_rs1 != 5'd0 && wb_write_adr == out_rs1)
        out_rs1_data <= wb_write_data;
      if (wb_wend && out_rs2 != 5'd0 && wb_write_adr == out_rs2)
        out_rs2_data <= wb_write_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, bypass, x0 forcing, load-use bubble,
// hold snoop, flush and immediate formats.
module tb_decode_stage;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rf_read_adr1;
  logic [4:0]  rf_read_adr2;
  logic [31:0] rf_read_data1;
  logic [31:0] rf_read_data2;
  logic        wb_wend;
  logic [4:0]  wb_write_adr;
  logic [31:0] wb_write_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7_5;

  logic [31:0] rf [32];
  int n_cmp;
  int n_bad;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .rf_read_adr1(rf_read_adr1), .rf_read_adr2(rf_read_adr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_wend(wb_wend), .wb_write_adr(wb_write_adr), .wb_write_data(wb_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7_5(out_funct7_5)
  );

  // Register file model with no x0 hardwiring.
  assign rf_read_data1 = rf[rf_read_adr1];
  assign rf_read_data2 = rf[rf_read_adr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'hDEAD;
    rf[5] = 32'h11;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_wend = 1'b0; wb_write_adr = 5'd0; wb_write_data = 32'h0;
    drive(enc_i(12'd5, 5'd0, 3'd0, 5'd9, OP_IMM), 32'h40);

    // 1. reset, release, then reset again mid-stream
    #2;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    step(); step();
    rst_n = 1'b1;
    check("rel_in_ready", 32'(in_ready), 32'h1);
    step();
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_pc", out_pc, 32'h40);
    check("first_imm", out_imm, 32'h5);
    in_pc = 32'h44;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_imm", out_imm, 32'h0);
    check("mid_rst_rd", 32'(out_rd), 32'h0);
    #1 rst_n = 1'b1;
    drive(enc_i(12'd5, 5'd0, 3'd0, 5'd9, OP_IMM), 32'h100);
    step();
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_pc", out_pc, 32'h100);

    // 2. writeback bypass beats the stale register file value
    drive(enc_r(5'd0, 5'd5, 5'd1), 32'h104);
    wb_wend = 1'b1; wb_write_adr = 5'd5; wb_write_data = 32'hAA;
    step();
    wb_wend = 1'b0;
    check("byp_rs1", out_rs1_data, 32'hAA);
    check("byp_rs2", out_rs2_data, 32'h0);
    check("byp_rd", 32'(out_rd), 32'h1);
    check("byp_op", 32'(out_opcode), 32'(OP_REG));
    drive(enc_r(5'd0, 5'd5, 5'd1), 32'h108);
    step();
    check("nobyp_rs1", out_rs1_data, 32'h11);

    // 3. x0 forced to zero despite register file and writeback
    drive(enc_i(12'd7, 5'd0, 3'd0, 5'd2, OP_IMM), 32'h10C);
    wb_wend = 1'b1; wb_write_adr = 5'd0; wb_write_data = 32'hBEEF;
    step();
    wb_wend = 1'b0;
    check("x0_rs1", out_rs1_data, 32'h0);
    check("x0_imm", out_imm, 32'h7);

    // 4. load-use: lw x3 then add x6,x3,x3
    drive(enc_i(12'd0, 5'd4, 3'd2, 5'd3, OP_LOAD), 32'h200);
    step();
    check("lw_op", 32'(out_opcode), 32'(OP_LOAD));
    drive(enc_r(5'd3, 5'd3, 5'd6), 32'h204);
    #1;
    check("lu_in_ready", 32'(in_ready), 32'h0);
    step();
    check("lu_bubble", 32'(out_valid), 32'h0);
    check("lu_retry_ready", 32'(in_ready), 32'h1);
    step();
    check("lu_add_valid", 32'(out_valid), 32'h1);
    check("lu_add_rd", 32'(out_rd), 32'h6);
    check("lu_add_pc", out_pc, 32'h204);
    // sw x3 after lw x3 stalls through rs2
    drive(enc_i(12'd0, 5'd4, 3'd2, 5'd3, OP_LOAD), 32'h208);
    step();
    drive(enc_s(12'd0, 5'd3, 5'd8), 32'h20C);
    #1;
    check("sw_in_ready", 32'(in_ready), 32'h0);
    step();
    check("sw_bubble", 32'(out_valid), 32'h0);
    step();
    check("sw_op", 32'(out_opcode), 32'(OP_STORE));
    // lui whose rs1 field reads 3 does not stall
    drive(enc_i(12'd0, 5'd4, 3'd2, 5'd3, OP_LOAD), 32'h210);
    step();
    drive({20'h00018, 5'd3, OP_LUI}, 32'h214);
    #1;
    check("lui_in_ready", 32'(in_ready), 32'h1);
    step();
    check("lui_valid", 32'(out_valid), 32'h1);
    check("lui_imm", out_imm, 32'h00018000);

    // 5. back-pressure with snoop on rs1
    drive(enc_i(12'd3, 5'd7, 3'd0, 5'd10, OP_IMM), 32'h300);
    step();
    out_ready = 1'b0;
    check("hold_rs1_init", out_rs1_data, 32'h0);
    drive(enc_i(12'd1, 5'd0, 3'd0, 5'd11, OP_IMM), 32'h304);
    wb_wend = 1'b1; wb_write_adr = 5'd7; wb_write_data = 32'h1234;
    #1;
    check("hold_in_ready", 32'(in_ready), 32'h0);
    step();
    wb_wend = 1'b0;
    check("snoop_rs1", out_rs1_data, 32'h1234);
    check("hold_valid", 32'(out_valid), 32'h1);
    check("hold_pc", out_pc, 32'h300);
    check("hold_rd", 32'(out_rd), 32'hA);
    check("hold_imm", out_imm, 32'h3);

    // 6. flush during hold, then during hazard
    flush = 1'b1;
    #1;
    check("fl_hold_ready", 32'(in_ready), 32'h1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_hold_valid", 32'(out_valid), 32'h0);
    step();
    check("fl_hold_dropped", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    drive(enc_i(12'd0, 5'd4, 3'd2, 5'd3, OP_LOAD), 32'h400);
    step();
    drive(enc_r(5'd3, 5'd3, 5'd6), 32'h404);
    flush = 1'b1;
    #1;
    check("fl_haz_ready", 32'(in_ready), 32'h1);
    step();
    flush = 1'b0;
    check("fl_haz_valid", 32'(out_valid), 32'h0);
    drive(enc_b(13'h1FFC, 5'd2, 5'd1), 32'h500);
    #1;
    check("fl_next_ready", 32'(in_ready), 32'h1);
    step();
    check("beq_valid", 32'(out_valid), 32'h1);
    check("beq_pc", out_pc, 32'h500);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    drive(enc_j(21'h000800, 5'd1), 32'h504);
    step();
    check("jal_imm", out_imm, 32'h00000800);
    drive(enc_s(12'hFFF, 5'd2, 5'd1), 32'h508);
    step();
    check("sw_imm", out_imm, 32'hFFFFFFFF);
    check("sw_pc", out_pc, 32'h508);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
